// File: rtl/alu32_if.sv
// Execution-stage ALU bus: operand/control request in, registered result and flags out.
// Latency: not applicable (signal bundle only).
// Backpressure: none; the consumer must take every out_valid cycle.
interface alu32_if;
   logic        in_valid;
   logic [1:0]  ctl;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] res;
   logic        out_valid;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   // Operand source side
   modport master (
      output in_valid, ctl, op1, op2,
      input  res, out_valid, zero, negative, carry, overflow
   );

   // ALU side
   modport slave (
      input  in_valid, ctl, op1, op2,
      output res, out_valid, zero, negative, carry, overflow
   );
endinterface

// File: rtl/alu32.sv
// 32-bit ALU (ADD/SUB/AND/OR) with registered result and zero/negative/carry/overflow flags.
// Latency: 1 cycle, one operation per cycle.
// Backpressure: none; result and flags hold while in_valid is low, out_valid drops.
module alu32 (
   input  logic   clk,
   input  logic   rst_n,
   alu32_if.slave bus
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   logic [32:0] w_sum;
   logic [32:0] w_diff;
   logic [31:0] w_res;
   logic        w_carry;
   logic        w_overflow;

   logic [31:0] r_res;
   logic        r_out_valid;
   logic        r_zero;
   logic        r_negative;
   logic        r_carry;
   logic        r_overflow;

   // Both adder paths are always computed; subtraction is op1 + ~op2 + 1 so its
   // carry-out is the "no borrow" indication.
   assign w_sum  = {1'b0, bus.op1} + {1'b0, bus.op2};
   assign w_diff = {1'b0, bus.op1} + {1'b0, ~bus.op2} + 33'd1;

   // Select result and arithmetic flags by operation; logic ops clear carry/overflow.
   always_comb begin
      w_res      = 32'd0;
      w_carry    = 1'b0;
      w_overflow = 1'b0;
      case (bus.ctl)
         OP_ADD: begin
            w_res      = w_sum[31:0];
            w_carry    = w_sum[32];
            w_overflow = (bus.op1[31] == bus.op2[31]) && (w_sum[31] != bus.op1[31]);
         end
         OP_SUB: begin
            w_res      = w_diff[31:0];
            w_carry    = w_diff[32];
            w_overflow = (bus.op1[31] != bus.op2[31]) && (w_diff[31] != bus.op1[31]);
         end
         OP_AND: w_res = bus.op1 & bus.op2;
         OP_OR:  w_res = bus.op1 | bus.op2;
         default: w_res = 32'd0;
      endcase
   end

   // Capture result and flags on valid input; otherwise hold them and drop out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res       <= 32'd0;
         r_out_valid <= 1'b0;
         r_zero      <= 1'b0;
         r_negative  <= 1'b0;
         r_carry     <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_res      <= w_res;
            r_zero     <= (w_res == 32'd0);
            r_negative <= w_res[31];
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
         end
      end
   end

   assign bus.res       = r_res;
   assign bus.out_valid = r_out_valid;
   assign bus.zero      = r_zero;
   assign bus.negative  = r_negative;
   assign bus.carry     = r_carry;
   assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed corner cases plus random traffic vs a reference model.
// Latency: expects results 1 cycle after the sampling edge.
// Backpressure: none; every output cycle is checked.
module tb_alu32;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   alu32_if u_if ();

   alu32 u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: what the outputs should show right now.
   logic [31:0] m_res;
   logic        m_vld, m_z, m_n, m_c, m_v;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Arithmetic on wide integers: carry from unsigned range, overflow from signed range.
   function automatic void ref_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic cy, output logic ov);
      longint ua, ub, sa, sb, us, ss;
      ua = a;
      ub = b;
      sa = $signed(a);
      sb = $signed(b);
      cy = 1'b0;
      ov = 1'b0;
      r  = 32'd0;
      case (c)
         2'd0: begin
            us = ua + ub;
            ss = sa + sb;
            r  = us[31:0];
            cy = (us > 64'sd4294967295);
            ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         2'd1: begin
            ss = sa - sb;
            r  = a - b;
            cy = (ua >= ub);
            ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
   endfunction

   task automatic model_reset();
      m_res = 32'd0;
      m_vld = 1'b0;
      m_z   = 1'b0;
      m_n   = 1'b0;
      m_c   = 1'b0;
      m_v   = 1'b0;
   endtask

   task automatic compare_all(input string tag);
      chk({tag, " res"}, {32'd0, u_if.res}, {32'd0, m_res});
      chk({tag, " vld/z/n/c/v"},
          {59'd0, u_if.out_valid, u_if.zero, u_if.negative, u_if.carry, u_if.overflow},
          {59'd0, m_vld, m_z, m_n, m_c, m_v});
   endtask

   // Drive one cycle of input, let the edge sample it, update the model and compare.
   task automatic step(input string tag, input logic v, input logic [1:0] c,
                       input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        cy, ov;
      @(negedge clk);
      u_if.in_valid = v;
      u_if.ctl      = c;
      u_if.op1      = a;
      u_if.op2      = b;
      @(posedge clk);
      #1;
      if (v) begin
         ref_op(c, a, b, r, cy, ov);
         m_res = r;
         m_z   = (r == 32'd0);
         m_n   = r[31];
         m_c   = cy;
         m_v   = ov;
      end
      m_vld = v;
      compare_all(tag);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // {out_valid, zero, negative, carry, overflow}
   function automatic logic [63:0] flags_now();
      return {59'd0, u_if.out_valid, u_if.zero, u_if.negative, u_if.carry, u_if.overflow};
   endfunction

   initial begin
      rst_n         = 1'b0;
      u_if.in_valid = 1'b0;
      u_if.ctl      = 2'b00;
      u_if.op1      = 32'd0;
      u_if.op2      = 32'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset res", {32'd0, u_if.res}, 64'd0);
      chk("reset flags", flags_now(), 64'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Op sweep on consecutive cycles
      step("sweep add", 1'b1, 2'b00, 32'h0000_00FF, 32'h0000_000F);
      chk("sweep add const", {32'd0, u_if.res}, {32'd0, 32'h0000_010E});
      step("sweep sub", 1'b1, 2'b01, 32'h0000_00FF, 32'h0000_000F);
      chk("sweep sub const", {32'd0, u_if.res}, {32'd0, 32'h0000_00F0});
      chk("sweep sub carry", {63'd0, u_if.carry}, 64'd1);
      step("sweep and", 1'b1, 2'b10, 32'h0000_00FF, 32'h0000_000F);
      chk("sweep and const", {32'd0, u_if.res}, {32'd0, 32'h0000_000F});
      step("sweep or", 1'b1, 2'b11, 32'h0000_00FF, 32'h0000_000F);
      chk("sweep or const", {32'd0, u_if.res}, {32'd0, 32'h0000_00FF});
      chk("sweep or vld", {63'd0, u_if.out_valid}, 64'd1);

      // ADD wrap: expect zero and carry
      step("add wrap", 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("add wrap const", {32'd0, u_if.res}, 64'd0);
      chk("add wrap flags", flags_now(), 64'b11010);

      // Signed overflow on add and sub
      step("add ovf", 1'b1, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
      chk("add ovf const", {32'd0, u_if.res}, {32'd0, 32'h8000_0000});
      chk("add ovf flags", flags_now(), 64'b10101);
      step("sub ovf", 1'b1, 2'b01, 32'h8000_0000, 32'h0000_0001);
      chk("sub ovf const", {32'd0, u_if.res}, {32'd0, 32'h7FFF_FFFF});
      chk("sub ovf flags", flags_now(), 64'b10011);

      // SUB with borrow
      step("sub borrow", 1'b1, 2'b01, 32'h0000_0005, 32'h0000_0007);
      chk("sub borrow const", {32'd0, u_if.res}, {32'd0, 32'hFFFF_FFFE});
      chk("sub borrow flags", flags_now(), 64'b10100);

      // Hold: valid ADD then three idle cycles with changing operands
      step("hold add", 1'b1, 2'b00, 32'h0000_1234, 32'h0000_0001);
      for (int i = 0; i < 3; i++) begin
         step("hold idle", 1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom);
         chk("hold res const", {32'd0, u_if.res}, {32'd0, 32'h0000_1235});
         chk("hold vld", {63'd0, u_if.out_valid}, 64'd0);
      end

      // Random traffic, mostly back-to-back
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
              pick_operand(), pick_operand());
      end

      // Mid-stream reset: asserted between edges, clears outputs without a clock
      step("pre rst", 1'b1, 2'b11, 32'hF0F0_0000, 32'h0000_0F0F);
      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.ctl      = 2'b00;
      u_if.op1      = 32'h8000_0001;
      u_if.op2      = 32'h8000_0001;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async rst res", {32'd0, u_if.res}, 64'd0);
      chk("async rst flags", flags_now(), 64'd0);
      @(posedge clk);
      #1;
      compare_all("in rst");

      // First edge after release samples normally
      @(negedge clk);
      rst_n = 1'b1;
      step("post rst", 1'b1, 2'b01, 32'h0000_0010, 32'h0000_0010);
      chk("post rst flags", flags_now(), 64'b11010);
      step("post rst idle", 1'b0, 2'b00, 32'd0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
